button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Reads a raw mechanical push-button (human input) and produces clean, debounced level and event outputs for the rest of the board design. It is the input-side counterpart of the LED blink/counter output path. The block synchronises the asynchronous pin, filters bounce with a cycle-accurate stability counter, and emits one-cycle press, release and long-press pulses. It also keeps a running press count that can be routed directly to LEDs.

Parameters:
DEBOUNCE_TICKS, 1000, consecutive stable clock cycles required to accept a level change; legal values are ≥1.
LONG_TICKS, 20000, cycles continuously in a pressed state before long_pulse fires; legal values are ≥1.
COUNT_W, 8, width of press_count.
ACTIVE_LOW, 0, set to 1 when the pin reads 0 while pressed.
REPEAT_TICKS, 5000, auto-repeat period; used only with the optional feature.

Ports:
clock  input  1  single system clock; all logic is on the posedge.
reset_n  input  1  asynchronous, active-low reset.
button  input  1  raw pin; asynchronous to clock and may bounce.
pressed  output  1  debounced level; 1 while the button is held.
press_pulse  output  1  one-cycle pulse when a press is accepted.
release_pulse  output  1  one-cycle pulse when a release is accepted.
long_pulse  output  1  one-cycle pulse after LONG_TICKS cycles held.
repeat_pulse  output  1  auto-repeat pulse; tied to 0 without the optional feature.
press_count  output  COUNT_W  number of accepted presses, modulo 2^COUNT_W.

Behaviour:
- Reset:
  - While reset_n=0, every output is 0, press_count=0, the FSM is in RELEASED, and all timers are 0.
  - Both synchroniser flops reset to the inactive level.
  - Reset is asynchronous on assertion. Deassertion is used directly; the board supplies a synchronised release.
- Input conditioning: button passes through a 2-flop synchroniser, then is XORed with ACTIVE_LOW to give btn_s (1 = pushed). This adds 2 cycles of latency.
- FSM has 4 states:
  - RELEASED: btn_s=1 → PRESS_CHK, stab_timer cleared.
  - PRESS_CHK:
    - btn_s=0 → RELEASED (bounce rejected; no output).
    - Otherwise stab_timer increments.
    - When btn_s has been 1 for DEBOUNCE_TICKS consecutive cycles → HELD. On that transition edge: press_pulse=1 for one cycle, pressed=1, press_count+1 with wrap to 0, hold_timer cleared.
  - HELD:
    - hold_timer increments and saturates.
    - When hold_timer reaches LONG_TICKS, long_pulse fires once per press.
    - btn_s=0 → RELEASE_CHK, stab_timer cleared.
  - RELEASE_CHK:
    - btn_s=1 → HELD. hold_timer is not cleared, so release bounce never re-fires press_pulse or long_pulse.
    - btn_s=0 for DEBOUNCE_TICKS consecutive cycles → RELEASED, release_pulse=1 for one cycle, pressed=0.
    - hold_timer keeps counting here, so long_pulse can fire in RELEASE_CHK.
- Latency: press_pulse asserts 2+DEBOUNCE_TICKS+1 cycles after a clean button edge. Release timing is symmetric.
- Timer widths: $clog2 of the largest compared value, plus 1. No overflow is permitted; hold_timer saturates at LONG_TICKS.
- Mutual exclusion: at most one of press_pulse and release_pulse is 1 in any cycle. long_pulse never coincides with press_pulse, since LONG_TICKS≥1.
- Reset mid-press clears everything, including press_count. If the button is still held after reset_n rises, a fresh press is detected after debounce.
- All outputs are registered.

Optional Feature:
Macro: BUTTON_DEBOUNCE_REPEAT_EN.
- Defined:
  - After long_pulse, repeat_pulse fires one cycle every REPEAT_TICKS cycles while in HELD or RELEASE_CHK.
  - The first repeat_pulse comes REPEAT_TICKS cycles after long_pulse.
  - The repeat timer clears on entry to RELEASED.
- Undefined: repeat_pulse is constant 0, and no repeat timer logic is generated.

Decomposition:
- Shared header/package button_pkg holds:
  - the state encoding localparams: RELEASED=2'd0, PRESS_CHK=2'd1, HELD=2'd2, RELEASE_CHK=2'd3;
  - the sim-friendly default tick constants.
- One sub-module, sync_2ff: a 2-flop synchroniser with async active-low reset and a reset-value parameter. It is reused by other pin inputs.

Test Plan:
1. Clean press (DEBOUNCE_TICKS=4, LONG_TICKS=10, COUNT_W=2): button 0→1 held for 8 cycles → press_pulse exactly once, 7 cycles after the edge; pressed=1; press_count=1.
2. Bounce rejection: toggle button every 2 cycles for 20 cycles (a high run shorter than 4 cycles) → no pulses, pressed=0, press_count=0. Then hold high → exactly one press_pulse.
3. Release bounce + long press: hold 12 cycles past press_pulse with one 2-cycle low glitch at cycle 5 → no release_pulse, no second press_pulse, long_pulse once at hold cycle 10. A clean release then gives release_pulse 7 cycles later.
4. Count wrap: 5 clean press/release pairs with COUNT_W=2 → press_count sequence 1,2,3,0,1.
5. Reset mid-operation: assert reset_n=0 during HELD → all outputs 0 within the same cycle (async), press_count=0. Release reset with the button still high → press_pulse 7 cycles later and press_count=1.
6. BUTTON_DEBOUNCE_REPEAT_EN with REPEAT_TICKS=3: hold 20 cycles past press_pulse → long_pulse at hold cycle 10, repeat_pulse at 13, 16, 19, and none after release. Without the macro, repeat_pulse stays 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encoding, simulation-sized tick values and timer sizing.
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   localparam int SIM_DEBOUNCE_TICKS = 4;
   localparam int SIM_LONG_TICKS     = 10;
   localparam int SIM_REPEAT_TICKS   = 3;
   localparam int SIM_COUNT_W        = 2;

   // Timers hold values up to max_val inclusive without wrapping.
   function automatic int timer_w(input int max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs.
// RST_VAL should be the pin's inactive level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= RST_VAL;
         r_s2 <= RST_VAL;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: press/release/long pulses and press counter.
// Optional auto-repeat output enabled by BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 1000,
   parameter int LONG_TICKS     = 20000,
   parameter int COUNT_W        = 8,
   parameter int ACTIVE_LOW     = 0,
   parameter int REPEAT_TICKS   = 5000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               button,
   output logic               pressed,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic               long_pulse,
   output logic               repeat_pulse,
   output logic [COUNT_W-1:0] press_count
);

   localparam logic POL = (ACTIVE_LOW != 0);
   localparam int   SW  = timer_w(DEBOUNCE_TICKS);
   localparam int   HW  = timer_w(LONG_TICKS);

   localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

   if (DEBOUNCE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
      $error("button_debounce: tick parameters must be >= 1");
   end

   logic               w_pin;
   logic               w_btn_s;
   logic               w_hold_run;
   state_t             r_state,   w_state;
   logic [SW-1:0]      r_stab,    w_stab;
   logic [HW-1:0]      r_hold,    w_hold;
   logic [COUNT_W-1:0] r_count,   w_count;
   logic               r_pressed, w_pressed;
   logic               r_press,   w_press;
   logic               r_rel,     w_rel;
   logic               r_long,    w_long;

   sync_2ff #(
      .RST_VAL (POL)
   ) u_sync (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_d     (button),
      .o_q     (w_pin)
   );

   assign w_btn_s    = w_pin ^ POL;
   assign w_hold_run = (r_state == HELD) || (r_state == RELEASE_CHK);

   always_comb begin
      w_state   = r_state;
      w_stab    = r_stab;
      w_hold    = r_hold;
      w_count   = r_count;
      w_pressed = r_pressed;
      w_press   = 1'b0;
      w_rel     = 1'b0;
      w_long    = 1'b0;
      unique case (r_state)
         RELEASED: begin
            if (w_btn_s) begin
               w_state = PRESS_CHK;
               w_stab  = '0;
            end
         end
         PRESS_CHK: begin
            if (!w_btn_s) begin
               w_state = RELEASED;
            end else if (r_stab == STAB_LAST) begin
               w_state   = HELD;
               w_press   = 1'b1;
               w_pressed = 1'b1;
               w_count   = r_count + 1'b1;
               w_hold    = '0;
            end else begin
               w_stab = r_stab + 1'b1;
            end
         end
         HELD: begin
            if (!w_btn_s) begin
               w_state = RELEASE_CHK;
               w_stab  = '0;
            end
         end
         RELEASE_CHK: begin
            if (w_btn_s) begin
               w_state = HELD;
            end else if (r_stab == STAB_LAST) begin
               w_state   = RELEASED;
               w_rel     = 1'b1;
               w_pressed = 1'b0;
            end else begin
               w_stab = r_stab + 1'b1;
            end
         end
         default: w_state = RELEASED;
      endcase
      // Hold time keeps running through release bounce; it saturates.
      if (w_hold_run && r_hold != HOLD_MAX) begin
         w_hold = r_hold + 1'b1;
         w_long = (r_hold == HOLD_LAST);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= RELEASED;
         r_stab    <= '0;
         r_hold    <= '0;
         r_count   <= '0;
         r_pressed <= 1'b0;
         r_press   <= 1'b0;
         r_rel     <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_stab    <= w_stab;
         r_hold    <= w_hold;
         r_count   <= w_count;
         r_pressed <= w_pressed;
         r_press   <= w_press;
         r_rel     <= w_rel;
         r_long    <= w_long;
      end
   end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
   localparam int            RW       = timer_w(REPEAT_TICKS);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

   logic [RW-1:0] r_rep, w_rep;
   logic          r_repeat, w_repeat;

   always_comb begin
      w_rep    = r_rep;
      w_repeat = 1'b0;
      if (w_long) begin
         w_rep = '0;
      end else if (w_hold_run && r_hold == HOLD_MAX) begin
         if (r_rep == REP_LAST) begin
            w_rep    = '0;
            w_repeat = 1'b1;
         end else begin
            w_rep = r_rep + 1'b1;
         end
      end
      if (w_state == RELEASED) w_rep = '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rep    <= '0;
         r_repeat <= 1'b0;
      end else begin
         r_rep    <= w_rep;
         r_repeat <= w_repeat;
      end
   end

   assign repeat_pulse = r_repeat;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign pressed       = r_pressed;
   assign press_pulse   = r_press;
   assign release_pulse = r_rel;
   assign long_pulse    = r_long;
   assign press_count   = r_count;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a run-length model.
// Honours BUTTON_DEBOUNCE_REPEAT_EN when the build defines it.
module tb_button_debounce;
   import button_pkg::*;

   localparam int D  = SIM_DEBOUNCE_TICKS;
   localparam int L  = SIM_LONG_TICKS;
   localparam int R  = SIM_REPEAT_TICKS;
   localparam int CW = SIM_COUNT_W;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic          button;
   logic          pressed;
   logic          press_pulse;
   logic          release_pulse;
   logic          long_pulse;
   logic          repeat_pulse;
   logic [CW-1:0] press_count;

   always #5 clock = ~clock;

   button_debounce #(
      .DEBOUNCE_TICKS (D),
      .LONG_TICKS     (L),
      .COUNT_W        (CW),
      .ACTIVE_LOW     (0),
      .REPEAT_TICKS   (R)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .button        (button),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .press_count   (press_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: debounced level flips after D+1 consecutive disagreeing
   // samples of the pin as seen two clocks late.
   bit   m_lvl, m_h1, m_h2;
   int   m_run, m_held, m_cnt;
   bit   e_press, e_rel, e_long, e_rep;
   logic [6:0] exp_v;
   logic [6:0] obs;

   assign obs = {pressed, press_pulse, release_pulse, long_pulse,
                 repeat_pulse, press_count};

   task automatic model_reset();
      m_lvl = 0; m_h1 = 0; m_h2 = 0;
      m_run = 0; m_held = 0; m_cnt = 0;
      e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
      exp_v = '0;
   endtask

   task automatic tick(input bit b);
      bit bs;
      button = b;
      @(posedge clock);
      e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
      if (reset_n) begin
         bs = m_h2; m_h2 = m_h1; m_h1 = b;
         if (m_lvl) begin
            m_held++;
            e_long = (m_held == L);
            e_rep  = REP_ON && m_held > L && ((m_held - L) % R == 0);
         end
         if (bs != m_lvl) m_run++;
         else m_run = 0;
         if (m_run == D + 1) begin
            m_lvl = !m_lvl;
            m_run = 0;
            if (m_lvl) begin
               e_press = 1;
               m_cnt   = (m_cnt + 1) % (1 << CW);
               m_held  = 0;
            end else begin
               e_rel = 1;
            end
         end
      end
      exp_v = {m_lvl, e_press, e_rel, e_long, e_rep, CW'(m_cnt)};
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      button  = 1'b0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      n_tests++;
      if (obs !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_hold obs=%b exp=%b", obs, 7'd0);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(0);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d obs=%b exp=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_clean_press();
      int p_idx = -1, n_p = 0, r_idx = -1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clean_press k=%0d obs=%b exp=%b", k, obs, exp_v);
         end
         if (press_pulse) begin
            n_p++;
            if (p_idx < 0) p_idx = k;
         end
      end
      n_tests++;
      if (p_idx != D + 3) begin
         n_fail++;
         $display("FAIL press_latency got=%0d exp=%0d", p_idx, D + 3);
      end
      n_tests++;
      if (n_p != 1 || pressed !== 1'b1 || press_count !== 2'd1) begin
         n_fail++;
         $display("FAIL press_once n=%0d pr=%b cnt=%0d exp 1/1/1",
                  n_p, pressed, press_count);
      end
      for (int k = 1; k <= 8; k++) begin
         tick(0);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clean_rel k=%0d obs=%b exp=%b", k, obs, exp_v);
         end
         if (release_pulse && r_idx < 0) r_idx = k;
      end
      n_tests++;
      if (r_idx != D + 3) begin
         n_fail++;
         $display("FAIL rel_latency got=%0d exp=%0d", r_idx, D + 3);
      end
   endtask

   task automatic test_bounce();
      int n_pul = 0, n_p = 0, p_idx = -1;
      for (int k = 0; k < 20; k++) begin
         tick(((k / 2) % 2) == 0);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bounce k=%0d obs=%b exp=%b", k, obs, exp_v);
         end
         if (press_pulse || release_pulse || long_pulse) n_pul++;
      end
      n_tests++;
      if (n_pul != 0 || pressed !== 1'b0 || press_count !== 2'd1) begin
         n_fail++;
         $display("FAIL bounce_reject pulses=%0d pr=%b cnt=%0d exp 0/0/1",
                  n_pul, pressed, press_count);
      end
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (press_pulse) begin
            n_p++;
            if (p_idx < 0) p_idx = k;
         end
      end
      n_tests++;
      if (n_p != 1 || p_idx != D + 3) begin
         n_fail++;
         $display("FAIL bounce_then_hold n=%0d idx=%0d exp 1/%0d",
                  n_p, p_idx, D + 3);
      end
   endtask

   task automatic test_long_glitch();
      int l_idx = -1, n_p = 0, n_r = 0, r_idx = -1;
      for (int k = 0; k < 12; k++) tick(0);
      for (int k = 0; k < 20 && !press_pulse; k++) tick(1);
      n_tests++;
      if (!press_pulse) begin
         n_fail++;
         $display("FAIL long_setup press_pulse=%b exp=1", press_pulse);
      end
      for (int h = 1; h <= 12; h++) begin
         tick(!(h == 5 || h == 6));
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL glitch h=%0d obs=%b exp=%b", h, obs, exp_v);
         end
         if (long_pulse && l_idx < 0) l_idx = h;
         if (press_pulse) n_p++;
         if (release_pulse) n_r++;
      end
      n_tests++;
      if (l_idx != L || n_p != 0 || n_r != 0) begin
         n_fail++;
         $display("FAIL long_glitch lidx=%0d np=%0d nr=%0d exp %0d/0/0",
                  l_idx, n_p, n_r, L);
      end
      for (int k = 1; k <= 8; k++) begin
         tick(0);
         if (release_pulse && r_idx < 0) r_idx = k;
      end
      n_tests++;
      if (r_idx != D + 3) begin
         n_fail++;
         $display("FAIL glitch_rel got=%0d exp=%0d", r_idx, D + 3);
      end
   endtask

   task automatic test_count_wrap();
      int exp_c [5] = '{1, 2, 3, 0, 1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 8; k++) begin
            tick(1);
            n_tests++;
            if (obs !== exp_v) begin
               n_fail++;
               $display("FAIL wrap_hi i=%0d obs=%b exp=%b", i, obs, exp_v);
            end
         end
         n_tests++;
         if (press_count !== CW'(exp_c[i])) begin
            n_fail++;
            $display("FAIL wrap_count i=%0d got=%0d exp=%0d",
                     i, press_count, exp_c[i]);
         end
         for (int k = 0; k < 8; k++) tick(0);
      end
   endtask

   task automatic test_reset_mid();
      int p_idx = -1;
      for (int k = 0; k < 9; k++) tick(1);
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== 7'd0) begin
         n_fail++;
         $display("FAIL async_reset obs=%b exp=%b", obs, 7'd0);
      end
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset k=%0d obs=%b exp=%b", k, obs, exp_v);
         end
         if (press_pulse && p_idx < 0) p_idx = k;
      end
      n_tests++;
      if (p_idx != D + 3 || press_count !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_repress idx=%0d cnt=%0d exp %0d/1",
                  p_idx, press_count, D + 3);
      end
      for (int k = 0; k < 10; k++) tick(0);
   endtask

   task automatic test_repeat();
      int unsigned rep_mask = 0, exp_mask;
      int l_idx = -1, n_after = 0;
      bit rel_seen = 0;
      exp_mask = REP_ON ? ((1 << (L + R)) | (1 << (L + 2 * R)) |
                           (1 << (L + 3 * R))) : 0;
      do_reset();
      for (int k = 0; k < 20 && !press_pulse; k++) tick(1);
      for (int h = 1; h <= 20; h++) begin
         tick(1);
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL repeat h=%0d obs=%b exp=%b", h, obs, exp_v);
         end
         if (repeat_pulse) rep_mask |= (1 << h);
         if (long_pulse && l_idx < 0) l_idx = h;
      end
      n_tests++;
      if (rep_mask != exp_mask || l_idx != L) begin
         n_fail++;
         $display("FAIL repeat_times mask=%h exp=%h lidx=%0d",
                  rep_mask, exp_mask, l_idx);
      end
      for (int k = 0; k < 20; k++) begin
         tick(0);
         if (rel_seen && repeat_pulse) n_after++;
         if (release_pulse) rel_seen = 1;
      end
      n_tests++;
      if (!rel_seen || n_after != 0) begin
         n_fail++;
         $display("FAIL repeat_after_rel seen=%b n=%0d exp 1/0",
                  rel_seen, n_after);
      end
   endtask

   task automatic test_random();
      bit lvl = 0;
      int len;
      for (int s = 0; s < 150; s++) begin
         lvl = !lvl;
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 30)
                                           : $urandom_range(1, 9);
         for (int k = 0; k < len; k++) begin
            tick(lvl);
            n_tests++;
            if (obs !== exp_v || (press_pulse && release_pulse)) begin
               n_fail++;
               $display("FAIL random s=%0d obs=%b exp=%b", s, obs, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_glitch();
      test_count_wrap();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
